// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane helpers
// for the data-memory access unit.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  function automatic logic [3:0] lane_wen(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (1'b1)
      size == SZ_B: lane_wen = 4'b0001 << off;
      size == SZ_H: lane_wen = off[1] ? 4'b1100 : 4'b0011;
      default:      lane_wen = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (1'b1)
      size == SZ_B: misaligned = 1'b0;
      size == SZ_H: misaligned = off[0];
      default:      misaligned = |off;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    unique case (1'b1)
      size == SZ_B: lane_data = {4{wdata[7:0]}};
      size == SZ_H: lane_data = {2{wdata[15:0]}};
      default:      lane_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// MEM-stage request bus plus data SRAM port.
// master = core/SRAM side, slave = access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              done;
  logic [31:0]       rdata;
  logic              adel;
  logic              ades;
  logic [ADDR_W-1:0] badvaddr;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output sram_rdata,
    input  stall, done, rdata, adel, ades,
    input  badvaddr, sram_en, sram_wen,
    input  sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  sram_rdata,
    output stall, done, rdata, adel, ades,
    output badvaddr, sram_en, sram_wen,
    output sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_load_ext.sv
// Byte/half lane select and sign/zero extension
// of raw SRAM read data.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (addr_i)
      2'd0: b = rdata_i[7:0];
      2'd1: b = rdata_i[15:8];
      2'd2: b = rdata_i[23:16];
      2'd3: b = rdata_i[31:24];
      default: b = 8'h00;
    endcase
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    unique case (1'b1)
      size_i == SZ_B:
        data_o = {{24{~unsigned_i & b[7]}}, b};
      size_i == SZ_H:
        data_o = {{16{~unsigned_i & h[15]}}, h};
      default:
        data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: sized loads/stores,
// SRAM latency stall and alignment errors.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int CW = $clog2(LATENCY + 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              adel_q;
  logic              ades_q;
  logic [ADDR_W-1:0] badvaddr_q;
  logic [31:0]       rdata_q;

  logic [1:0]        size_d;
  logic [ADDR_W-1:0] addr_d;
  logic              mis_d;
  logic [31:0]       ext_data;
  logic              acc;

  // Size 3 folds to word; without checking, drop low bits instead.
  always_comb begin
    size_d = (bus.req_size == 2'd3) ? SZ_W : bus.req_size;
    mis_d  = (ALIGN_CHECK != 0)
           && misaligned(size_d, bus.req_addr[1:0]);
    addr_d = bus.req_addr;
    if (ALIGN_CHECK == 0) begin
      unique case (1'b1)
        size_d == SZ_B: addr_d = bus.req_addr;
        size_d == SZ_H: addr_d[0] = 1'b0;
        default:        addr_d[1:0] = 2'b00;
      endcase
    end
  end

  mem_load_ext u_ext (
    .rdata_i    (bus.sram_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      badvaddr_q <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid && mis_d) begin
            adel_q     <= ~bus.req_we;
            ades_q     <= bus.req_we;
            badvaddr_q <= bus.req_addr;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else if (bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= size_d;
            uns_q   <= bus.req_unsigned;
            addr_q  <= addr_d;
            wdata_q <= lane_data(size_d, bus.req_wdata);
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            rdata_q <= we_q ? 32'h0 : ext_data;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          done_q     <= 1'b0;
          adel_q     <= 1'b0;
          ades_q     <= 1'b0;
          badvaddr_q <= '0;
          rdata_q    <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign acc = (state_q == S_ACCESS);

  assign bus.stall = (state_q == S_IDLE && bus.req_valid)
                   || acc;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.adel     = adel_q;
  assign bus.ades     = ades_q;
  assign bus.badvaddr = badvaddr_q;

  assign bus.sram_en    = acc;
  assign bus.sram_wen   = (acc && we_q)
                        ? lane_wen(size_q, addr_q[1:0])
                        : 4'b0000;
  assign bus.sram_addr  = acc ? {addr_q[ADDR_W-1:2], 2'b00}
                              : '0;
  assign bus.sram_wdata = acc ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: one unit at LATENCY=1, one at LATENCY=3,
// each with its own byte-lane SRAM model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, sel;
  logic rv, we, uns;
  logic [1:0] sz;
  logic [31:0] addr, wd;

  mem_access_unit_if #(.ADDR_W(32)) b1 ();
  mem_access_unit_if #(.ADDR_W(32)) b3 ();

  mem_access_unit #(.ADDR_W(32), .LATENCY(1), .ALIGN_CHECK(1))
    u1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_access_unit #(.ADDR_W(32), .LATENCY(3), .ALIGN_CHECK(1))
    u3 (.clk(clk), .rst(rst3), .bus(b3));

  assign b1.req_valid    = rv & ~sel;
  assign b3.req_valid    = rv & sel;
  assign b1.req_we       = we;
  assign b3.req_we       = we;
  assign b1.req_size     = sz;
  assign b3.req_size     = sz;
  assign b1.req_unsigned = uns;
  assign b3.req_unsigned = uns;
  assign b1.req_addr     = addr;
  assign b3.req_addr     = addr;
  assign b1.req_wdata    = wd;
  assign b3.req_wdata    = wd;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  always @(posedge clk)
    if (b1.sram_en)
      for (int i = 0; i < 4; i++)
        if (b1.sram_wen[i])
          mem1[b1.sram_addr[9:2]][8*i +: 8] <= b1.sram_wdata[8*i +: 8];

  always @(posedge clk)
    if (b3.sram_en)
      for (int j = 0; j < 4; j++)
        if (b3.sram_wen[j])
          mem3[b3.sram_addr[9:2]][8*j +: 8] <= b3.sram_wdata[8*j +: 8];

  assign b1.sram_rdata = mem1[b1.sram_addr[9:2]];
  assign b3.sram_rdata = mem3[b3.sram_addr[9:2]];

  wire        o_stall = sel ? b3.stall    : b1.stall;
  wire        o_done  = sel ? b3.done     : b1.done;
  wire [31:0] o_rdata = sel ? b3.rdata    : b1.rdata;
  wire        o_adel  = sel ? b3.adel     : b1.adel;
  wire        o_ades  = sel ? b3.ades     : b1.ades;
  wire [31:0] o_bad   = sel ? b3.badvaddr : b1.badvaddr;
  wire        o_en    = sel ? b3.sram_en  : b1.sram_en;
  wire [3:0]  o_wen   = sel ? b3.sram_wen : b1.sram_wen;
  wire [31:0] o_saddr = sel ? b3.sram_addr : b1.sram_addr;
  wire [31:0] o_swd   = sel ? b3.sram_wdata : b1.sram_wdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".stall"}, {31'b0, o_stall}, 32'd0);
    chk({tag, ".done"},  {31'b0, o_done},  32'd0);
    chk({tag, ".rdata"}, o_rdata, 32'd0);
    chk({tag, ".adel"},  {31'b0, o_adel},  32'd0);
    chk({tag, ".ades"},  {31'b0, o_ades},  32'd0);
    chk({tag, ".bad"},   o_bad, 32'd0);
    chk({tag, ".en"},    {31'b0, o_en},    32'd0);
    chk({tag, ".wen"},   {28'b0, o_wen},   32'd0);
    chk({tag, ".saddr"}, o_saddr, 32'd0);
    chk({tag, ".swd"},   o_swd, 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic w, input logic [1:0] s,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] ewen,
                     input logic [31:0] ewd,
                     input logic [31:0] erd);
    int lat;
    lat = sel ? 3 : 1;
    @(negedge clk);
    rv = 1'b1; we = w; sz = s; uns = u; addr = a; wd = d;
    #1;
    chk({tag, ".stall0"}, {31'b0, o_stall}, 32'd1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      rv = 1'b0;
      #1;
      chk({tag, ".en"},    {31'b0, o_en},    {31'b0, c <= lat});
      chk({tag, ".stall"}, {31'b0, o_stall}, {31'b0, c <= lat});
      chk({tag, ".done"},  {31'b0, o_done},  {31'b0, c == lat + 1});
      if (c == 1) begin
        chk({tag, ".wen"},   {28'b0, o_wen}, {28'b0, ewen});
        chk({tag, ".saddr"}, o_saddr, {a[31:2], 2'b00});
        if (w) chk({tag, ".swd"}, o_swd, ewd);
      end
      if (c == lat + 1) begin
        chk({tag, ".rdata"}, o_rdata, erd);
        chk({tag, ".err"}, {30'b0, o_adel, o_ades}, 32'd0);
      end
    end
  endtask

  task automatic err(input string tag, input logic w,
                     input logic [1:0] s, input logic [31:0] a);
    @(negedge clk);
    rv = 1'b1; we = w; sz = s; uns = 1'b0; addr = a; wd = 32'h0;
    #1;
    chk({tag, ".stall0"}, {31'b0, o_stall}, 32'd1);
    @(negedge clk);
    rv = 1'b0;
    #1;
    chk({tag, ".done"},  {31'b0, o_done},  32'd1);
    chk({tag, ".adel"},  {31'b0, o_adel},  {31'b0, ~w});
    chk({tag, ".ades"},  {31'b0, o_ades},  {31'b0, w});
    chk({tag, ".bad"},   o_bad, a);
    chk({tag, ".en"},    {31'b0, o_en},    32'd0);
    chk({tag, ".stall"}, {31'b0, o_stall}, 32'd0);
    @(negedge clk);
    #1;
    chk_idle({tag, ".after"});
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; sel = 1'b0;
    rv = 1'b0; we = 1'b0; uns = 1'b0; sz = 2'd0;
    addr = 32'h0; wd = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("rst1");
    sel = 1'b1;
    #1;
    chk_idle("rst3");
    sel = 1'b0;
    rst1 = 1'b0; rst3 = 1'b0;

    run("sw",  1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    run("lw",  0, 2'd2, 0, 32'h100, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF);
    run("sw2", 1, 2'd2, 0, 32'h100, 32'h80FF7F01, 4'b1111, 32'h80FF7F01, 32'h0);
    run("lb1", 0, 2'd0, 0, 32'h101, 32'h0, 4'b0000, 32'h0, 32'h0000007F);
    run("lb3", 0, 2'd0, 0, 32'h103, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80);
    run("lbu", 0, 2'd0, 1, 32'h103, 32'h0, 4'b0000, 32'h0, 32'h00000080);
    run("lh",  0, 2'd1, 0, 32'h102, 32'h0, 4'b0000, 32'h0, 32'hFFFF80FF);
    run("lhu", 0, 2'd1, 1, 32'h102, 32'h0, 4'b0000, 32'h0, 32'h000080FF);
    run("lw3", 0, 2'd3, 0, 32'h100, 32'h0, 4'b0000, 32'h0, 32'h80FF7F01);
    run("sb",  1, 2'd0, 0, 32'h202, 32'h000000AB, 4'b0100, 32'hABABABAB, 32'h0);
    run("sh",  1, 2'd1, 0, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 32'h0);
    run("lhs", 0, 2'd1, 1, 32'h202, 32'h0, 4'b0000, 32'h0, 32'h00001234);
    err("adel", 1'b0, 2'd2, 32'h301);
    err("ades", 1'b1, 2'd1, 32'h303);

    sel = 1'b1;
    run("sw_l3", 1, 2'd2, 0, 32'h40, 32'h11223344, 4'b1111, 32'h11223344, 32'h0);
    run("lw_l3", 0, 2'd2, 0, 32'h40, 32'h0, 4'b0000, 32'h0, 32'h11223344);

    @(negedge clk);
    rv = 1'b1; we = 1'b0; sz = 2'd2; uns = 1'b0; addr = 32'h40;
    @(negedge clk);
    rv = 1'b0;
    #1;
    chk("rstacc.en", {31'b0, o_en}, 32'd1);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk_idle("rstacc");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("rstacc.nodone", {31'b0, o_done}, 32'd0);
    end
    run("lw_post", 0, 2'd0, 1, 32'h43, 32'h0, 4'b0000, 32'h0, 32'h00000011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
